// File: rtl/sram_pkg.sv
// Shared definitions for the 1R1W SRAM array and its storage core.
//   DEF_*      default parameter values
//   clog2()    address width for a given depth
//   seg_width  bits per write-mask segment
package sram_pkg;

    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_MASK_SEGS  = 1;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int seg_width(input int data_width, input int mask_segs);
        return data_width / mask_segs;
    endfunction

endpackage

// File: rtl/sram_1r1w_core.sv
// Raw DEPTH x DATA_WIDTH storage with per-segment write enables and a
// registered read port. No reset and no validity tracking, so the whole
// module can be swapped for a hard macro.
//   i_clock                     clock
//   i_rd_en, i_rd_addr          read request; o_rd_data updates only when i_rd_en=1
//   o_rd_data                   registered read data (old contents on same-address write)
//   i_wr_en, i_wr_addr          write request
//   i_wr_data, i_wr_mask        write data and per-segment enables
module sram_1r1w_core
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MASK_SEGS  = DEF_MASK_SEGS,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic                  i_clock,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [MASK_SEGS-1:0]  i_wr_mask
);

    localparam int SEG = seg_width(DATA_WIDTH, MASK_SEGS);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clock) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
        if (i_wr_en) begin
            for (int s = 0; s < MASK_SEGS; s++) begin
                if (i_wr_mask[s]) begin
                    r_mem[i_wr_addr][s*SEG +: SEG] <= i_wr_data[s*SEG +: SEG];
                end
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sram_array_1r1w_bypass.sv
// 1R1W SRAM array with valid bits, write-first bypass, flush and a
// one-cycle registered read port.
//   clock, reset            single clock, synchronous active-high reset
//   R0_en, R0_addr          read request
//   R0_data, R0_hit         read result one cycle later, held while R0_en=0
//   W0_en, W0_addr          write request
//   W0_data, W0_mask        write data and per-segment enables
//   flush                   invalidate every entry (data is kept)
module sram_array_1r1w_bypass
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MASK_SEGS  = DEF_MASK_SEGS,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  R0_en,
    input  logic [AW-1:0]         R0_addr,
    output logic [DATA_WIDTH-1:0] R0_data,
    output logic                  R0_hit,
    input  logic                  W0_en,
    input  logic [AW-1:0]         W0_addr,
    input  logic [DATA_WIDTH-1:0] W0_data,
    input  logic [MASK_SEGS-1:0]  W0_mask,
    input  logic                  flush
);

    localparam int SEG = seg_width(DATA_WIDTH, MASK_SEGS);

    logic [DEPTH-1:0]      r_valid;
    logic                  r_old_ok;
    logic                  r_hit;
    logic [DATA_WIDTH-1:0] r_byp_bits;
    logic [DATA_WIDTH-1:0] r_byp_data;

    logic [DATA_WIDTH-1:0] w_core_q;
    logic [DATA_WIDTH-1:0] w_bitmask;
    logic                  w_wr_fire;
    logic                  w_byp;
    logic [DEPTH-1:0]      w_valid_nxt;

    genvar g;
    generate
        for (g = 0; g < DATA_WIDTH; g++) begin : g_bitmask
            assign w_bitmask[g] = W0_mask[g/SEG];
        end
    endgenerate

    assign w_wr_fire = W0_en & (|W0_mask);
    assign w_byp     = w_wr_fire & (R0_addr == W0_addr);

    // Flush clears first so a same-cycle write still leaves its entry valid.
    always_comb begin
        w_valid_nxt = flush ? '0 : r_valid;
        if (w_wr_fire) begin
            w_valid_nxt[W0_addr] = 1'b1;
        end
    end

    // The core returns pre-write contents; the bypass overlay captured here
    // replaces the freshly written segments. Everything is sampled from the
    // pre-edge valid bits, so a same-cycle flush does not affect the read.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid    <= '0;
            r_old_ok   <= 1'b0;
            r_hit      <= 1'b0;
            r_byp_bits <= '0;
            r_byp_data <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (R0_en) begin
                r_old_ok   <= r_valid[R0_addr];
                r_hit      <= r_valid[R0_addr] | w_byp;
                r_byp_bits <= w_byp ? w_bitmask : '0;
                r_byp_data <= w_byp ? (W0_data & w_bitmask) : '0;
            end
        end
    end

    sram_1r1w_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .MASK_SEGS  (MASK_SEGS),
        .AW         (AW)
    ) u_core (
        .i_clock   (clock),
        .i_rd_en   (R0_en & ~reset),
        .i_rd_addr (R0_addr),
        .o_rd_data (w_core_q),
        .i_wr_en   (W0_en & ~reset),
        .i_wr_addr (W0_addr),
        .i_wr_data (W0_data),
        .i_wr_mask (W0_mask)
    );

    // Built only from registers: invalid entries read as zero.
    assign R0_data = ((r_old_ok ? w_core_q : '0) & ~r_byp_bits) | r_byp_data;
    assign R0_hit  = r_hit;

endmodule

// File: tb/tb_sram_array_1r1w_bypass.sv
module tb_sram_array_1r1w_bypass;

    localparam int DW    = 256;
    localparam int DEPTH = 8;
    localparam int SEGS  = 4;
    localparam int AW    = 3;
    localparam int SEG   = DW / SEGS;

    logic           clock = 1'b0;
    logic           reset;
    logic           R0_en;
    logic [AW-1:0]  R0_addr;
    logic [DW-1:0]  R0_data;
    logic           R0_hit;
    logic           W0_en;
    logic [AW-1:0]  W0_addr;
    logic [DW-1:0]  W0_data;
    logic [SEGS-1:0] W0_mask;
    logic           flush;

    always #5 clock = ~clock;

    sram_array_1r1w_bypass #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MASK_SEGS  (SEGS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .R0_en   (R0_en),
        .R0_addr (R0_addr),
        .R0_data (R0_data),
        .R0_hit  (R0_hit),
        .W0_en   (W0_en),
        .W0_addr (W0_addr),
        .W0_data (W0_data),
        .W0_mask (W0_mask),
        .flush   (flush)
    );

    typedef struct {
        string           name;
        logic            rst;
        logic            ren;
        logic [AW-1:0]   raddr;
        logic            wen;
        logic [AW-1:0]   waddr;
        logic [DW-1:0]   wdata;
        logic [SEGS-1:0] wmask;
        logic            flush;
        logic            chk;
        logic [DW-1:0]   exp_data;
        logic            exp_hit;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain array of entries plus validity flags.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_valid [DEPTH];
    logic [DW-1:0] m_data;
    logic          m_hit;

    function automatic vec_t mk(string name, logic rst, logic ren, logic [AW-1:0] raddr,
                                logic wen, logic [AW-1:0] waddr, logic [DW-1:0] wdata,
                                logic [SEGS-1:0] wmask, logic fl, logic chk,
                                logic [DW-1:0] ed, logic eh);
        vec_t v;
        v.name = name; v.rst = rst; v.ren = ren; v.raddr = raddr;
        v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.wmask = wmask;
        v.flush = fl; v.chk = chk; v.exp_data = ed; v.exp_hit = eh;
        return v;
    endfunction

    function automatic logic [DW-1:0] dpat(int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return {8{w}};
    endfunction

    task automatic model_step(input vec_t v);
        logic [DW-1:0] rd;
        bit wr;
        if (v.rst) begin
            for (int a = 0; a < DEPTH; a++) m_valid[a] = 1'b0;
            m_data = '0;
            m_hit  = 1'b0;
        end else begin
            wr = v.wen && (v.wmask != '0);
            if (v.ren) begin
                rd = m_valid[v.raddr] ? m_mem[v.raddr] : '0;
                m_hit = m_valid[v.raddr];
                if (wr && (v.waddr == v.raddr)) begin
                    for (int s = 0; s < SEGS; s++)
                        if (v.wmask[s]) rd[s*SEG +: SEG] = v.wdata[s*SEG +: SEG];
                    m_hit = 1'b1;
                end
                m_data = rd;
            end
            if (v.flush)
                for (int a = 0; a < DEPTH; a++) m_valid[a] = 1'b0;
            if (wr) begin
                for (int s = 0; s < SEGS; s++)
                    if (v.wmask[s]) m_mem[v.waddr][s*SEG +: SEG] = v.wdata[s*SEG +: SEG];
                m_valid[v.waddr] = 1'b1;
            end
        end
    endtask

    task automatic apply(input vec_t v);
        reset   = v.rst;
        R0_en   = v.ren;
        R0_addr = v.raddr;
        W0_en   = v.wen;
        W0_addr = v.waddr;
        W0_data = v.wdata;
        W0_mask = v.wmask;
        flush   = v.flush;
        model_step(v);
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] ed, input logic eh);
        n_checks++;
        if (R0_data !== ed || R0_hit !== eh) begin
            n_errors++;
            $display("FAIL %s: got data=%h hit=%b, want data=%h hit=%b",
                     name, R0_data, R0_hit, ed, eh);
        end
    endtask

    initial begin
        logic [DW-1:0] a5;
        logic [DW-1:0] ones;
        logic [DW-1:0] zero;
        logic [DW-1:0] mixed;
        logic [DW-1:0] e6;
        logic [DW-1:0] held;
        vec_t v;

        a5    = {32{8'hA5}};
        ones  = '1;
        zero  = '0;
        mixed = {{SEG{1'b1}}, {SEG{1'b0}}, {SEG{1'b1}}, {SEG{1'b0}}};
        e6    = {8{32'h6666_0006}};

        //              name             rst ren ra  wen wa  wdata   mask    fl chk exp     hit
        vecs.push_back(mk("reset0",        1, 0, 0,  0, 0, zero,   4'h0,   0, 1, zero,   0));
        vecs.push_back(mk("reset1",        1, 1, 3,  1, 3, ones,   4'hF,   0, 1, zero,   0));
        vecs.push_back(mk("hold_post_rst", 0, 0, 0,  1, 3, a5,     4'hF,   0, 1, zero,   0));
        vecs.push_back(mk("raw_addr3",     0, 1, 3,  0, 0, zero,   4'h0,   0, 1, a5,     1));
        vecs.push_back(mk("hold_a",        0, 0, 0,  1, 5, ones,   4'hF,   0, 1, a5,     1));
        vecs.push_back(mk("hold_b",        0, 0, 0,  1, 5, zero,   4'b0101,0, 1, a5,     1));
        vecs.push_back(mk("masked_addr5",  0, 1, 5,  0, 0, zero,   4'h0,   0, 1, mixed,  1));
        vecs.push_back(mk("bypass_inval",  0, 1, 2,  1, 2, 256'h1234, 4'h1, 0, 1, 256'h1234, 1));
        vecs.push_back(mk("read_inval7",   0, 1, 7,  0, 0, zero,   4'h0,   0, 1, zero,   0));
        vecs.push_back(mk("mask0_bypass",  0, 1, 7,  1, 7, ones,   4'h0,   0, 1, zero,   0));
        vecs.push_back(mk("mask0_after",   0, 1, 7,  0, 0, zero,   4'h0,   0, 1, zero,   0));
        vecs.push_back(mk("rw_diff_addr",  0, 1, 3,  1, 5, ones,   4'hF,   0, 1, a5,     1));
        vecs.push_back(mk("rw_diff_after", 0, 1, 5,  0, 0, zero,   4'h0,   0, 1, ones,   1));
        for (int i = 0; i < DEPTH; i++)
            vecs.push_back(mk("fill", 0, 0, 0, 1, AW'(i), dpat(i), 4'hF, 0, 0, zero, 0));
        vecs.push_back(mk("flush_wr_rd6",  0, 1, 6,  1, 6, e6,     4'hF,   1, 1, e6,     1));
        for (int i = 0; i < DEPTH; i++)
            vecs.push_back(mk("post_flush", 0, 1, AW'(i), 0, 0, zero, 4'h0, 0, 1,
                              (i == 6) ? e6 : zero, (i == 6)));
        vecs.push_back(mk("pre_rst_wr1",   0, 1, 6,  1, 1, dpat(1),4'hF,   0, 1, e6,     1));
        vecs.push_back(mk("rst_mid_wr",    1, 1, 1,  1, 1, ones,   4'hF,   0, 1, zero,   0));
        vecs.push_back(mk("rst_hold",      1, 0, 0,  0, 0, zero,   4'h0,   0, 1, zero,   0));
        vecs.push_back(mk("first_after",   0, 1, 4,  1, 4, a5,     4'hF,   0, 1, a5,     1));
        vecs.push_back(mk("addr1_inval",   0, 1, 1,  0, 0, zero,   4'h0,   0, 1, zero,   0));
        vecs.push_back(mk("addr4_valid",   0, 1, 4,  0, 0, zero,   4'h0,   0, 1, a5,     1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (vecs[i].chk) check(vecs[i].name, vecs[i].exp_data, vecs[i].exp_hit);
        end

        // Output hold across three idle read cycles while the entry changes.
        held = dpat(9);
        apply(mk("h_wr", 0, 0, 0, 1, 0, held, 4'hF, 0, 0, zero, 0));
        apply(mk("h_rd", 0, 1, 0, 0, 0, zero, 4'h0, 0, 0, zero, 0));
        check("hold_read", held, 1'b1);
        apply(mk("h1", 0, 0, 3, 1, 0, ones, 4'hF, 0, 0, zero, 0));
        check("hold_cyc1", held, 1'b1);
        apply(mk("h2", 0, 0, 5, 0, 0, zero, 4'h0, 1, 0, zero, 0));
        check("hold_cyc2", held, 1'b1);
        apply(mk("h3", 0, 0, 7, 1, 2, zero, 4'h3, 0, 0, zero, 0));
        check("hold_cyc3", held, 1'b1);
        apply(mk("h_rd0", 0, 1, 0, 0, 0, zero, 4'h0, 0, 0, zero, 0));
        check("hold_flushed", zero, 1'b0);

        // Random soak against the reference model.
        for (int n = 0; n < 10000; n++) begin
            v = mk("soak", 0, 0, 0, 0, 0, zero, 4'h0, 0, 0, zero, 0);
            v.rst   = ($urandom_range(0, 299) == 0);
            v.ren   = 1'($urandom_range(0, 1));
            v.raddr = AW'($urandom_range(0, DEPTH - 1));
            v.wen   = 1'($urandom_range(0, 1));
            v.waddr = ($urandom_range(0, 3) == 0) ? v.raddr : AW'($urandom_range(0, DEPTH - 1));
            for (int k = 0; k < DW / 32; k++) v.wdata[k*32 +: 32] = $urandom();
            v.wmask = SEGS'($urandom_range(0, (1 << SEGS) - 1));
            v.flush = ($urandom_range(0, 24) == 0);
            apply(v);
            check("soak", m_data, m_hit);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
